// File: rtl/datapath_pkg.sv
// Shared datapath definitions: word width and word type for operand steering blocks.
package datapath_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

endpackage : datapath_pkg

// File: rtl/dff_ar.sv
// Generic D flop bank with asynchronous active-high reset to a parameterised value.
//  clk  in   1  rising-edge clock
//  rst  in   1  asynchronous, active-high reset; loads RST_VAL while high
//  d    in   W  data in
//  q    out  W  registered data
module dff_ar #(
   parameter int unsigned   W       = 1,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // State register: reset is level-sensitive and overrides the clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RST_VAL;
      end else begin
         q <= d;
      end
   end

endmodule : dff_ar

// File: rtl/mux2.sv
// Two-way word selector with a combinational result and a registered copy.
//  clk     in   1      rising-edge clock for out_q / ctrl_q
//  rst     in   1      asynchronous, active-high reset of out_q / ctrl_q
//  ctrl    in   1      select: 0 -> a, 1 -> b
//  a       in   WIDTH  data input 0
//  b       in   WIDTH  data input 1
//  out     out  WIDTH  combinational selection (independent of clk/rst)
//  out_q   out  WIDTH  out registered one cycle
//  ctrl_q  out  1      ctrl registered one cycle; tags the source of out_q
module mux2
   import datapath_pkg::*;
#(
   parameter int unsigned      WIDTH     = WORD_W,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             ctrl_q
);

   localparam int unsigned REG_W = WIDTH + 1;

   // Conditional operator keeps simulation X-merging on an unknown select.
   assign out = ctrl ? b : a;

   // Source tag and data share one register so they always stay aligned.
   dff_ar #(
      .W       (REG_W),
      .RST_VAL ({1'b0, RESET_VAL})
   ) u_out_reg (
      .clk (clk),
      .rst (rst),
      .d   ({ctrl, out}),
      .q   ({ctrl_q, out_q})
   );

endmodule : mux2

// File: tb/tb_mux2.sv
// Self-checking bench for mux2: vector table for the combinational path,
// hand sequences for reset behaviour, and a queue scoreboard for the register.
module tb_mux2;
   import datapath_pkg::*;

   logic  clk;
   logic  rst;
   logic  ctrl;
   word_t a;
   word_t b;
   word_t out;
   word_t out_q;
   logic  ctrl_q;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic  ctrl;
      word_t a;
      word_t b;
      word_t exp;
   } vec_t;

   typedef struct {
      logic  ctrl;
      word_t out;
   } reg_exp_t;

   vec_t     vecs[8];
   reg_exp_t sb[$];

   mux2 dut (
      .clk    (clk),
      .rst    (rst),
      .ctrl   (ctrl),
      .a      (a),
      .b      (b),
      .out    (out),
      .out_q  (out_q),
      .ctrl_q (ctrl_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'd0,          32'd0,           32'd0};
      vecs[1] = '{1'b1, 32'd5,          32'd4,           32'd4};
      vecs[2] = '{1'b1, 32'd13,         32'd66,          32'd66};
      vecs[3] = '{1'b1, 32'd749,        32'd619,         32'd619};
      vecs[4] = '{1'b0, 32'd786,        32'd4932,        32'd786};
      vecs[5] = '{1'b0, 32'd65035,      32'd555489,      32'd65035};
      vecs[6] = '{1'b1, 32'h0000_0000,  32'hFFFF_FFFF,   32'hFFFF_FFFF};
      vecs[7] = '{1'b0, 32'h8000_0001,  32'hFFFF_FFFF,   32'h8000_0001};

      // Reset state, no clock edge yet
      rst = 1'b1; ctrl = 1'b0; a = '0; b = '0;
      #1;
      chk("reset out_q", {1'b0, out_q}, 33'd0);
      chk("reset ctrl_q", {32'd0, ctrl_q}, 33'd0);
      chk("reset out", {1'b0, out}, 33'd0);

      @(negedge clk);
      rst = 1'b0;

      // Combinational table
      for (int i = 0; i < 8; i++) begin
         ctrl = vecs[i].ctrl; a = vecs[i].a; b = vecs[i].b;
         #5;
         chk($sformatf("vec%0d out", i), {1'b0, out}, {1'b0, vecs[i].exp});
      end

      // Load a nonzero value, then async reset mid-cycle
      @(negedge clk);
      ctrl = 1'b1; a = 32'h1234; b = 32'hABCD;
      @(posedge clk); #1;
      chk("load out_q", {1'b0, out_q}, {1'b0, 32'hABCD});
      chk("load ctrl_q", {32'd0, ctrl_q}, 33'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async rst out_q", {1'b0, out_q}, 33'd0);
      chk("async rst ctrl_q", {32'd0, ctrl_q}, 33'd0);

      // out keeps tracking inputs during reset; register held
      a = 32'd7; b = 32'd123; ctrl = 1'b1;
      #1;
      chk("out during rst", {1'b0, out}, {1'b0, 32'd123});
      @(posedge clk); #1;
      chk("held out_q", {1'b0, out_q}, 33'd0);
      chk("held ctrl_q", {32'd0, ctrl_q}, 33'd0);

      // Release, then capture only after the next posedge
      @(negedge clk);
      rst = 1'b0; ctrl = 1'b1; a = 32'd13; b = 32'd66;
      #1;
      chk("pre-edge out_q", {1'b0, out_q}, 33'd0);
      @(posedge clk); #1;
      chk("post-edge out_q", {1'b0, out_q}, {1'b0, 32'd66});
      chk("post-edge ctrl_q", {32'd0, ctrl_q}, 33'd1);

      // Unknown select merges differing bits to X
      @(negedge clk);
      ctrl = 1'bx; a = 32'hF0F0_0000; b = 32'hF0F0_FFFF;
      #1;
      chk("x select out", {1'b0, out}, {1'b0, 32'hF0F0_XXXX});

      // Randomised run with scoreboard on the registered path
      for (int i = 0; i < 1000; i++) begin
         reg_exp_t e;
         @(negedge clk);
         ctrl = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         #1;
         chk("rand out", {1'b0, out}, {1'b0, (ctrl ? b : a)});
         e.ctrl = ctrl;
         e.out  = ctrl ? b : a;
         sb.push_back(e);
         @(posedge clk); #1;
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: queue empty, got out_q %h", out_q);
         end else begin
            e = sb.pop_front();
            chk("rand out_q", {1'b0, out_q}, {1'b0, e.out});
            chk("rand ctrl_q", {32'd0, ctrl_q}, {32'd0, e.ctrl});
         end
      end
      chk("scoreboard drained", 33'(sb.size()), 33'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mux2
